gcd_stream: RTL and testbench



---
 rtl/gcd_stream.sv | 185 ++++++++++++++++++
 tb/tb_gcd_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stream.sv
// gcd_stream: streaming binary (Stein) GCD engine with a generic operand width.
//
// Operands enter through a valid/ready handshake and are reduced by the Stein
// algorithm. The result and an iteration count are held under a valid/ready
// output handshake that tolerates backpressure.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   a_i/b_i carry valid operands
//   in_ready_o   engine is idle and will capture operands on this edge
//   a_i, b_i     unsigned operands, WIDTH bits
//   out_valid_o  result_o/cycles_o are valid (held until out_ready_i)
//   out_ready_i  consumer accepts the result
//   result_o     gcd(a, b), WIDTH bits
//   cycles_o     compute cycles spent on this result, saturating, CYC_W bits
//   busy_o       a computation is in progress
module gcd_stream #(
  parameter int WIDTH = 32,
  parameter int CYC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [CYC_W-1:0] cycles_o,
  output logic             busy_o
);

  // Common power-of-two exponent never exceeds WIDTH-1 for non-zero operands.
  localparam int K_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    FACTOR2,
    STRIP_A,
    STRIP_B,
    CMP,
    SUB,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;

  // Saturating next value of the cycle counter; used on every compute edge.
  logic [CYC_W-1:0] cnt_inc;
  logic [WIDTH-1:0] diff;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);
  assign diff    = b_q - a_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cycles_d = cycles_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          k_d     = '0;
          cnt_d   = '0;
          state_d = CHK;
        end
      end

      CHK: begin
        cnt_d = cnt_inc;
        if (a_q == '0 || b_q == '0) begin
          // gcd(x,0) = x, and gcd(0,0) is defined as 0.
          result_d = a_q | b_q;
          cycles_d = cnt_inc;
          state_d  = HOLD;
        end else begin
          state_d = FACTOR2;
        end
      end

      FACTOR2: begin
        cnt_d = cnt_inc;
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + K_W'(1);
        end else begin
          state_d = STRIP_A;
        end
      end

      STRIP_A: begin
        cnt_d = cnt_inc;
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else begin
          state_d = STRIP_B;
        end
      end

      STRIP_B: begin
        cnt_d = cnt_inc;
        if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else begin
          state_d = CMP;
        end
      end

      CMP: begin
        cnt_d = cnt_inc;
        if (a_q > b_q) begin
          a_d = b_q;
          b_d = a_q;
        end
        state_d = SUB;
      end

      SUB: begin
        // a <= b is guaranteed by CMP, so the difference cannot underflow.
        cnt_d = cnt_inc;
        b_d   = diff;
        if (diff == '0) begin
          result_d = a_q << k_q;
          cycles_d = cnt_inc;
          state_d  = HOLD;
        end else begin
          state_d = STRIP_B;
        end
      end

      HOLD: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q != IDLE) && (state_q != HOLD);
  assign result_o    = result_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_gcd_stream.sv
// tb_gcd_stream: self-checking bench for gcd_stream.
//
// Two instances share clock and reset: a 32-bit engine with a 16-bit cycle
// counter, and an 8-bit engine with a 4-bit cycle counter that makes counter
// saturation easy to reach. Results are compared against Euclid's algorithm
// and cycle counts against a step count derived from the state rules.
module tb_gcd_stream;

  logic clk;
  logic rst_n;

  logic        v32, rdy32, ov32, or32, busy32;
  logic [31:0] a32, b32, res32;
  logic [15:0] cyc32;

  logic        v8, rdy8, ov8, or8, busy8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  cyc8;

  int checks;
  int failures;

  localparam int LIM = 3000;

  gcd_stream #(.WIDTH(32), .CYC_W(16)) dut32 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (v32),
    .in_ready_o  (rdy32),
    .a_i         (a32),
    .b_i         (b32),
    .out_valid_o (ov32),
    .out_ready_i (or32),
    .result_o    (res32),
    .cycles_o    (cyc32),
    .busy_o      (busy32)
  );

  gcd_stream #(.WIDTH(8), .CYC_W(4)) dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (v8),
    .in_ready_o  (rdy8),
    .a_i         (a8),
    .b_i         (b8),
    .out_valid_o (ov8),
    .out_ready_i (or8),
    .result_o    (res8),
    .cycles_o    (cyc8),
    .busy_o      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference gcd by Euclid's remainder method, independent of Stein.
  function automatic int unsigned model_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Cycles spent: one per edge in a compute state, saturated to cyc_w bits.
  function automatic int model_cycles(input int unsigned x, input int unsigned y, input int cyc_w);
    int unsigned t;
    int n;
    n = 1;
    if (x != 0 && y != 0) begin
      while (x[0] == 1'b0 && y[0] == 1'b0) begin
        x = x >> 1; y = y >> 1; n++;
      end
      n++;
      while (x[0] == 1'b0) begin
        x = x >> 1; n++;
      end
      n++;
      do begin
        while (y[0] == 1'b0) begin
          y = y >> 1; n++;
        end
        n++;
        n++;
        if (x > y) begin
          t = x; x = y; y = t;
        end
        y = y - x;
        n++;
      end while (y != 0);
    end
    if (n > (1 << cyc_w) - 1) n = (1 << cyc_w) - 1;
    return n;
  endfunction

  // Drive one operand pair through the input handshake and wait for HOLD.
  // lat counts edges from the capture edge to the edge that entered HOLD.
  task automatic run_op(input bit sel8, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [15:0] cyc,
                        output int lat, output bit to, output bit busy_ok);
    int n;
    to = 1'b0;
    busy_ok = 1'b1;
    lat = 0;
    @(negedge clk);
    if (sel8) begin v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
    else      begin v32 = 1'b1; a32 = a; b32 = b; end
    n = 0;
    while (!(sel8 ? rdy8 : rdy32) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    v32 = 1'b0;
    while (!(sel8 ? ov8 : ov32) && lat < LIM) begin
      if (!(sel8 ? busy8 : busy32)) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!(sel8 ? ov8 : ov32)) to = 1'b1;
    if (sel8 ? busy8 : busy32) busy_ok = 1'b0;
    res = sel8 ? {24'b0, res8} : res32;
    cyc = sel8 ? {12'b0, cyc8} : cyc32;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({rdy32, ov32, busy32, res32, cyc32} !== {1'b1, 1'b0, 1'b0, 32'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset32: got rdy=%b ov=%b busy=%b res=%h cyc=%h, want 1 0 0 0 0",
               rdy32, ov32, busy32, res32, cyc32);
    end
    checks++;
    if ({rdy8, ov8, busy8, res8, cyc8} !== {1'b1, 1'b0, 1'b0, 8'h0, 4'h0}) begin
      failures++;
      $display("FAIL reset8: got rdy=%b ov=%b busy=%b res=%h cyc=%h, want 1 0 0 0 0",
               rdy8, ov8, busy8, res8, cyc8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] res; logic [15:0] cyc; int lat; bit to, bok;
    or32 = 1'b1;
    run_op(1'b0, 32'd12, 32'd18, res, cyc, lat, to, bok);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout: got timeout=%b, want 0", to); end
    checks++;
    if (lat !== 12) begin failures++; $display("FAIL basic_latency: got %0d, want 12", lat); end
    checks++;
    if (res !== 32'd6) begin failures++; $display("FAIL basic_result: got %0d, want 6", res); end
    checks++;
    if (cyc !== 16'd12) begin failures++; $display("FAIL basic_cycles: got %0d, want 12", cyc); end
    checks++;
    if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy: busy profile got %b, want 1", bok); end
  endtask

  task automatic test_zero_operands();
    logic [31:0] res; logic [15:0] cyc; int lat; bit to, bok;
    logic [31:0] ta [3] = '{32'd0, 32'd9, 32'd0};
    logic [31:0] tb [3] = '{32'd7, 32'd0, 32'd0};
    logic [31:0] te [3] = '{32'd7, 32'd9, 32'd0};
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, ta[i], tb[i], res, cyc, lat, to, bok);
      checks++;
      if (res !== te[i] || cyc !== 16'd1 || lat !== 1 || to) begin
        failures++;
        $display("FAIL zero_op%0d: got res=%0d cyc=%0d lat=%0d to=%b, want res=%0d cyc=1 lat=1 to=0",
                 i, res, cyc, lat, to, te[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] res; logic [15:0] cyc; int lat; bit to, bok;
    or32 = 1'b1;
    or8 = 1'b1;
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, res, cyc, lat, to, bok);
    checks++;
    if (res !== 32'h8000_0000 || to) begin
      failures++;
      $display("FAIL msb_pair_result: got %h to=%b, want 80000000", res, to);
    end
    checks++;
    if (cyc !== 16'(model_cycles(32'h8000_0000, 32'h8000_0000, 16))) begin
      failures++;
      $display("FAIL msb_pair_cycles: got %0d, want %0d", cyc,
               model_cycles(32'h8000_0000, 32'h8000_0000, 16));
    end
    run_op(1'b1, 32'd255, 32'd17, res, cyc, lat, to, bok);
    checks++;
    if (res !== 32'd17 || to) begin failures++; $display("FAIL w8_255_17: got %0d to=%b, want 17", res, to); end
    run_op(1'b1, 32'd17, 32'd255, res, cyc, lat, to, bok);
    checks++;
    if (res !== 32'd17 || to) begin failures++; $display("FAIL w8_swap: got %0d to=%b, want 17", res, to); end
    run_op(1'b1, 32'd255, 32'd1, res, cyc, lat, to, bok);
    checks++;
    if (res !== 32'd1 || cyc !== 16'd15 || to) begin
      failures++;
      $display("FAIL w8_saturate: got res=%0d cyc=%0d to=%b, want res=1 cyc=15", res, cyc, to);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; logic [15:0] cyc, want_cyc; int lat, n; bit to, bok;
    want_cyc = 16'(model_cycles(100, 75, 16));
    or32 = 1'b0;
    run_op(1'b0, 32'd100, 32'd75, res, cyc, lat, to, bok);
    checks++;
    if (res !== 32'd25 || cyc !== want_cyc || to) begin
      failures++;
      $display("FAIL bp_result: got res=%0d cyc=%0d to=%b, want 25 %0d", res, cyc, to, want_cyc);
    end
    v32 = 1'b1; a32 = 32'd5; b32 = 32'd10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ov32 !== 1'b1 || res32 !== 32'd25 || cyc32 !== want_cyc || rdy32 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got ov=%b res=%0d cyc=%0d rdy=%b, want 1 25 %0d 0",
                 i, ov32, res32, cyc32, rdy32, want_cyc);
      end
    end
    or32 = 1'b1; a32 = 32'd48; b32 = 32'd36;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy32 !== 1'b1 || ov32 !== 1'b0 || res32 !== 32'd25 || cyc32 !== want_cyc) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b ov=%b res=%0d cyc=%0d, want 1 0 25 %0d",
               rdy32, ov32, res32, cyc32, want_cyc);
    end
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1 || rdy32 !== 1'b0) begin
      failures++;
      $display("FAIL bp_capture: got busy=%b rdy=%b, want 1 0", busy32, rdy32);
    end
    n = 0;
    while (!ov32 && n < LIM) begin @(negedge clk); n++; end
    checks++;
    if (ov32 !== 1'b1 || res32 !== 32'd12) begin
      failures++;
      $display("FAIL bp_next: got ov=%b res=%0d, want 1 12", ov32, res32);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [15:0] cyc; int lat; bit to, bok;
    or32 = 1'b1;
    @(negedge clk);
    v32 = 1'b1; a32 = 32'd1023; b32 = 32'd1;
    while (!rdy32) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy32 !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b, want 1", busy32); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov32, busy32, res32, cyc32} !== {1'b0, 1'b0, 32'h0, 16'h0}) begin
      failures++;
      $display("FAIL mid_async_reset: got ov=%b busy=%b res=%h cyc=%h, want 0 0 0 0",
               ov32, busy32, res32, cyc32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy32 !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b, want 1", rdy32); end
    run_op(1'b0, 32'd48, 32'd36, res, cyc, lat, to, bok);
    checks++;
    if (res !== 32'd12 || cyc !== 16'(model_cycles(48, 36, 16)) || to) begin
      failures++;
      $display("FAIL mid_after: got res=%0d cyc=%0d to=%b, want 12 %0d",
               res, cyc, to, model_cycles(48, 36, 16));
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b; logic [15:0] cyc; int lat, sh; bit to, bok;
    or32 = 1'b1;
    or8 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit sel8;
      sel8 = (i >= 200);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        sh = $urandom_range(1, 6);
        a = a << sh;
        b = b << sh;
      end
      if ($urandom_range(0, 24) == 0) a = 32'd0;
      if ($urandom_range(0, 24) == 0) b = 32'd0;
      if (sel8) begin a = a & 32'hFF; b = b & 32'hFF; end
      run_op(sel8, a, b, res, cyc, lat, to, bok);
      checks++;
      if (to || res !== model_gcd(a, b) || cyc !== 16'(model_cycles(a, b, sel8 ? 4 : 16))
          || (!sel8 && lat !== int'(cyc))) begin
        failures++;
        $display("FAIL rand%0d: a=%0d b=%0d got res=%0d cyc=%0d lat=%0d to=%b, want res=%0d cyc=%0d",
                 i, a, b, res, cyc, lat, to, model_gcd(a, b), model_cycles(a, b, sel8 ? 4 : 16));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    v32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
    test_reset();
    test_basic();
    test_zero_operands();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
